// File: rtl/majority_pkg.sv
// Shared constants, FSM state type and request validation for the majority pattern generator.
package majority_pkg;

  localparam int N_BITS = 12;

  localparam logic [2:0] CLS_MORE0 = 3'b100;
  localparam logic [2:0] CLS_EQUAL = 3'b010;
  localparam logic [2:0] CLS_MORE1 = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A request is rejected when its class is not one-hot or its ones count cannot
  // produce that majority in a 12-bit word.
  function automatic logic isBadRequest(input logic [2:0] reqClass, input logic [3:0] reqOnes);
    logic bad;
    bad = 1'b0;
    case (reqClass)
      CLS_MORE0: bad = (reqOnes > 4'd5);
      CLS_EQUAL: bad = (reqOnes != 4'd6);
      CLS_MORE1: bad = (reqOnes < 4'd7) || (reqOnes > 4'd12);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/majority_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifting left with feedback into bit 0.
module majority_lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] safeSeed;
  logic       feedback;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  assign safeSeed = (seed == 8'h00) ? 8'h01 : seed;
  assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign q        = lfsr_q;

  // Reload the seed on reset, otherwise step only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= safeSeed;
    end else if (en) begin
      lfsr_q <= {lfsr_q[6:0], feedback};
    end
  end

endmodule

// File: rtl/majority_pattern_gen.sv
// Generates a 12-bit word with a requested number of 1s, one bit per cycle,
// filling free positions from an LFSR while guaranteeing the exact ones count.
module majority_pattern_gen #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_class,
  input  logic [3:0]  req_ones,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_word,
  output logic        out_err
);

  import majority_pkg::*;

  state_t      state_q;
  logic [3:0]  bitIdx_q;
  logic [3:0]  onesLeft_q;
  logic [11:0] word_q;
  logic        err_q;
  logic [7:0]  lfsrQ;
  logic [3:0]  slotsLeft;
  logic        wordBit_d;

  majority_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == BUILD),
    .seed  (LFSR_SEED),
    .q     (lfsrQ)
  );

  assign slotsLeft = 4'(N_BITS) - bitIdx_q;

  // Force a 1 when every remaining slot is needed, a 0 once the ones are used up,
  // and take the LFSR bit when either choice still reaches the target count.
  always_comb begin
    wordBit_d = 1'b0;
    if (onesLeft_q == slotsLeft) begin
      wordBit_d = 1'b1;
    end else if (onesLeft_q == 4'd0) begin
      wordBit_d = 1'b0;
    end else begin
      wordBit_d = lfsrQ[0];
    end
  end

  // Request/build/result FSM with its registered word, error flag and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitIdx_q   <= 4'd0;
      onesLeft_q <= 4'd0;
      word_q     <= 12'h000;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            word_q <= 12'h000;
            if (isBadRequest(req_class, req_ones)) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              err_q      <= 1'b0;
              bitIdx_q   <= 4'd0;
              onesLeft_q <= req_ones;
              state_q    <= BUILD;
            end
          end
        end
        BUILD: begin
          word_q[bitIdx_q] <= wordBit_d;
          if (wordBit_d) begin
            onesLeft_q <= onesLeft_q - 4'd1;
          end
          if (bitIdx_q == 4'(N_BITS - 1)) begin
            state_q <= DONE;
          end else begin
            bitIdx_q <= bitIdx_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_word  = word_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_majority_pattern_gen.sv
// Self-checking bench for majority_pattern_gen: directed vector table, hold/back-to-back,
// mid-build reset replay and a run of random legal requests against a reference model.
module tb_majority_pattern_gen;

  import majority_pkg::*;

  localparam logic [7:0] SEED = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_class;
  logic [3:0]  req_ones;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_word;
  logic        out_err;

  int          passCount  = 0;
  int          checkCount = 0;
  logic [7:0]  modelLfsr;

  typedef struct {
    logic [2:0]  cls;
    logic [3:0]  ones;
    logic        expErr;
    logic        checkFixed;
    logic [11:0] fixedWord;
  } vec_t;

  vec_t vecs [12];

  majority_pattern_gen #(.LFSR_SEED(SEED)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_class (req_class),
    .req_ones  (req_ones),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_err   (out_err)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Guard against a hung DUT handshake.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passCount, checkCount);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference word builder; consumes 12 LFSR steps like a real build.
  task automatic modelBuild(input logic [3:0] ones, output logic [11:0] w);
    int r;
    logic b;
    r = int'(ones);
    w = 12'h000;
    for (int i = 0; i < 12; i++) begin
      if (r == 12 - i)   b = 1'b1;
      else if (r == 0)   b = 1'b0;
      else               b = modelLfsr[0];
      w[i] = b;
      if (b) r--;
      modelLfsr = {modelLfsr[6:0], ^(modelLfsr & 8'hB8)};
    end
  endtask

  task automatic applyStimulus(input logic [2:0] cls, input logic [3:0] ones);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("reqReadyBeforeAccept", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_class = cls;
    req_ones  = ones;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) checkOutput("resultTimeout", 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("idleAfterHandshake", {30'd0, out_valid, req_ready}, 32'd1);
  endtask

  task automatic runRequest(input string tag, input logic [2:0] cls, input logic [3:0] ones,
                            input logic expErr, output logic [11:0] w);
    logic [11:0] expWord;
    int lat;
    expWord = 12'h000;
    if (!expErr) modelBuild(ones, expWord);
    applyStimulus(cls, ones);
    waitResult(lat);
    checkOutput({tag, " latency"}, 32'(lat), expErr ? 32'd0 : 32'd12);
    checkOutput({tag, " err"}, 32'(out_err), 32'(expErr));
    checkOutput({tag, " word"}, 32'(out_word), 32'(expWord));
    w = out_word;
    handshake();
  endtask

  initial begin
    logic [11:0] refWord;
    logic [11:0] w;
    logic [11:0] held;
    logic [11:0] expHold;
    logic [2:0]  cls;
    logic [3:0]  ones;
    logic [2:0]  derived;
    int          lat;
    int          pick;

    vecs[0]  = '{3'b100, 4'd7,  1'b1, 1'b0, 12'h000};
    vecs[1]  = '{3'b011, 4'd3,  1'b1, 1'b0, 12'h000};
    vecs[2]  = '{3'b000, 4'd0,  1'b1, 1'b0, 12'h000};
    vecs[3]  = '{3'b110, 4'd6,  1'b1, 1'b0, 12'h000};
    vecs[4]  = '{3'b010, 4'd5,  1'b1, 1'b0, 12'h000};
    vecs[5]  = '{3'b001, 4'd6,  1'b1, 1'b0, 12'h000};
    vecs[6]  = '{3'b001, 4'd13, 1'b1, 1'b0, 12'h000};
    vecs[7]  = '{3'b100, 4'd0,  1'b0, 1'b1, 12'h000};
    vecs[8]  = '{3'b001, 4'd12, 1'b0, 1'b1, 12'hFFF};
    vecs[9]  = '{3'b010, 4'd6,  1'b0, 1'b0, 12'h000};
    vecs[10] = '{3'b100, 4'd5,  1'b0, 1'b0, 12'h000};
    vecs[11] = '{3'b001, 4'd7,  1'b0, 1'b0, 12'h000};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_class = 3'b000;
    req_ones  = 4'd0;
    out_ready = 1'b0;
    modelLfsr = SEED;

    #12;
    checkOutput("resetReqReady", 32'(req_ready), 32'd1);
    checkOutput("resetOutValid", 32'(out_valid), 32'd0);
    checkOutput("resetOutWord",  32'(out_word),  32'd0);
    checkOutput("resetOutErr",   32'(out_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference word straight after power-on reset.
    runRequest("pwrOn001x9", CLS_MORE1, 4'd9, 1'b0, refWord);
    checkOutput("pwrOn001x9 popcount", 32'($countones(refWord)), 32'd9);

    for (int v = 0; v < 12; v++) begin
      runRequest($sformatf("vec%0d", v), vecs[v].cls, vecs[v].ones, vecs[v].expErr, w);
      if (vecs[v].checkFixed) checkOutput($sformatf("vec%0d fixedWord", v), 32'(w), 32'(vecs[v].fixedWord));
      if (!vecs[v].expErr) checkOutput($sformatf("vec%0d popcount", v), 32'($countones(w)), 32'(vecs[v].ones));
    end

    // Result held while the consumer stalls; a pending request waits for IDLE.
    modelBuild(4'd6, expHold);
    applyStimulus(CLS_EQUAL, 4'd6);
    waitResult(lat);
    checkOutput("hold latency", 32'(lat), 32'd12);
    held = out_word;
    checkOutput("hold word", 32'(held), 32'(expHold));
    req_valid = 1'b1;
    req_class = CLS_MORE1;
    req_ones  = 4'd7;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d word", k), 32'(out_word), 32'(held));
      checkOutput($sformatf("hold%0d state", k), {30'd0, out_valid, req_ready}, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("b2b notAcceptedOnHandshake", {30'd0, out_valid, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("b2b acceptedNextEdge", 32'(req_ready), 32'd0);
    modelBuild(4'd7, expHold);
    waitResult(lat);
    checkOutput("b2b latency", 32'(lat), 32'd12);
    checkOutput("b2b word", 32'(out_word), 32'(expHold));
    handshake();

    // Reset in the middle of a build, then replay the power-on request.
    applyStimulus(CLS_EQUAL, 4'd6);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset outValid", 32'(out_valid), 32'd0);
    checkOutput("midReset reqReady", 32'(req_ready), 32'd1);
    checkOutput("midReset outWord",  32'(out_word),  32'd0);
    checkOutput("midReset outErr",   32'(out_err),   32'd0);
    #1;
    rst_n = 1'b1;
    modelLfsr = SEED;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("postReset noEmit", {30'd0, out_valid, req_ready}, 32'd1);
    runRequest("afterReset001x9", CLS_MORE1, 4'd9, 1'b0, w);
    checkOutput("resetReplay", 32'(w), 32'(refWord));

    // Random legal requests.
    for (int n = 0; n < 1000; n++) begin
      pick = int'($urandom_range(0, 2));
      if (pick == 0) begin
        cls  = CLS_MORE0;
        ones = 4'($urandom_range(0, 5));
      end else if (pick == 1) begin
        cls  = CLS_EQUAL;
        ones = 4'd6;
      end else begin
        cls  = CLS_MORE1;
        ones = 4'($urandom_range(7, 12));
      end
      runRequest($sformatf("rand%0d", n), cls, ones, 1'b0, w);
      checkOutput($sformatf("rand%0d popcount", n), 32'($countones(w)), 32'(ones));
      if ($countones(w) < 6)       derived = CLS_MORE0;
      else if ($countones(w) == 6) derived = CLS_EQUAL;
      else                         derived = CLS_MORE1;
      checkOutput($sformatf("rand%0d class", n), 32'(derived), 32'(cls));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
